// File: rtl/bp_be_dcache_trace_pkg.sv
`default_nettype none
// ============================================================================
// bp_be_dcache_trace_pkg
// Shared opcode/packet types, size constants and helpers for the trace responder.
// Rev 1.0
// ============================================================================

// Packet layout {opcode, paddr, data}, MSB first.
`define DECLARE_BP_BE_DCACHE_TRACE_PKT_S(paddr_w, dword_w) \
  typedef struct packed {                                   \
    bp_be_dcache_trace_op_s opcode;                         \
    logic [paddr_w-1:0]     paddr;                          \
    logic [dword_w-1:0]     data;                           \
  } bp_be_dcache_trace_pkt_s

package bp_be_dcache_trace_pkg;

  typedef struct packed {
    logic       store;
    logic       uns;
    logic [1:0] size;
  } bp_be_dcache_trace_op_s;

  localparam logic [1:0] c_size_b = 2'd0;
  localparam logic [1:0] c_size_h = 2'd1;
  localparam logic [1:0] c_size_w = 2'd2;
  localparam logic [1:0] c_size_d = 2'd3;

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_wait = 2'd1,
    e_resp = 2'd2
  } bp_be_dcache_trace_state_e;

  function automatic logic [7:0] size_byte_mask(input logic [1:0] size);
    case (size)
      c_size_b: size_byte_mask = 8'h01;
      c_size_h: size_byte_mask = 8'h03;
      c_size_w: size_byte_mask = 8'h0F;
      default:  size_byte_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] offset, input logic [1:0] size);
    case (size)
      c_size_b: is_misaligned = 1'b0;
      c_size_h: is_misaligned = offset[0];
      c_size_w: is_misaligned = |offset[1:0];
      default:  is_misaligned = |offset;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/bp_be_dcache_trace_mem.sv
`default_nettype none
// ============================================================================
// bp_be_dcache_trace_mem
// Dword array: byte-masked synchronous write, asynchronous read with align/extend.
// Rev 1.0
// ============================================================================
module bp_be_dcache_trace_mem
  import bp_be_dcache_trace_pkg::*;
  #(
    parameter int els_p    = 512,
    parameter int lg_els_p = $clog2(els_p)
  )
  (
    input  logic                clk,
    input  logic                i_w_v,
    input  logic [lg_els_p-1:0] i_w_index,
    input  logic [2:0]          i_w_offset,
    input  logic [1:0]          i_w_size,
    input  logic [63:0]         i_w_data,
    input  logic [lg_els_p-1:0] i_r_index,
    input  logic [2:0]          i_r_offset,
    input  logic [1:0]          i_r_size,
    input  logic                i_r_uns,
    output logic [63:0]         o_r_data
  );

  logic [63:0] r_mem [els_p];
  logic [7:0]  w_wmask;
  logic [63:0] w_wdata;
  logic [63:0] w_rshift;

  assign w_wmask  = size_byte_mask(i_w_size) << i_w_offset;
  assign w_wdata  = i_w_data << {i_w_offset, 3'b000};
  assign w_rshift = r_mem[i_r_index] >> {i_r_offset, 3'b000};

  always_ff @(posedge clk) begin
    if (i_w_v) begin
      for (int i = 0; i < 8; i++) begin
        if (w_wmask[i]) r_mem[i_w_index][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    o_r_data = w_rshift;
    case (i_r_size)
      c_size_b: o_r_data = i_r_uns ? {56'd0, w_rshift[7:0]}  : {{56{w_rshift[7]}},  w_rshift[7:0]};
      c_size_h: o_r_data = i_r_uns ? {48'd0, w_rshift[15:0]} : {{48{w_rshift[15]}}, w_rshift[15:0]};
      c_size_w: o_r_data = i_r_uns ? {32'd0, w_rshift[31:0]} : {{32{w_rshift[31]}}, w_rshift[31:0]};
      default:  o_r_data = w_rshift;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bp_be_dcache_trace_responder.sv
`default_nettype none
// ============================================================================
// bp_be_dcache_trace_responder
// Trace-ring responder: one request in flight, programmable response latency.
// Rev 1.0
// ============================================================================
module bp_be_dcache_trace_responder
  import bp_be_dcache_trace_pkg::*;
  #(
    parameter int paddr_width_p  = 40,
    parameter int dword_width_p  = 64,
    parameter int opcode_width_p = 4,
    parameter int els_p          = 512,
    parameter int latency_p      = 2,
    parameter int ring_width_p   = opcode_width_p + paddr_width_p + dword_width_p
  )
  (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [ring_width_p-1:0] tr_pkt_i,
    input  logic                    tr_pkt_v_i,
    output logic                    tr_pkt_yumi_o,
    output logic [ring_width_p-1:0] tr_pkt_o,
    output logic                    tr_pkt_v_o,
    input  logic                    tr_pkt_ready_i,
    output logic                    misalign_o
  );

  `DECLARE_BP_BE_DCACHE_TRACE_PKT_S(paddr_width_p, dword_width_p);

  localparam int c_lg_els = $clog2(els_p);
  localparam int c_cnt_w  = (latency_p > 0) ? $clog2(latency_p + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_latency = c_cnt_w'(latency_p);

  bp_be_dcache_trace_state_e r_state, w_state_n;
  bp_be_dcache_trace_pkt_s   w_req, r_resp;
  bp_be_dcache_trace_op_s    r_req_op, w_rd_op;
  logic [paddr_width_p-1:0]  r_req_paddr, w_rd_paddr;
  logic [c_cnt_w-1:0]        r_cnt;
  logic                      r_misalign;
  logic                      w_accept, w_req_misalign, w_rd_misalign;
  logic [63:0]               w_mem_rdata, w_resp_data;

  assign w_req          = tr_pkt_i;
  assign w_accept       = tr_pkt_yumi_o;
  assign w_req_misalign = is_misaligned(w_req.paddr[2:0], w_req.opcode.size);

  // With zero latency the response is captured on the accept edge, so read from the live request.
  assign w_rd_op       = (r_state == e_idle) ? w_req.opcode : r_req_op;
  assign w_rd_paddr    = (r_state == e_idle) ? w_req.paddr  : r_req_paddr;
  assign w_rd_misalign = is_misaligned(w_rd_paddr[2:0], w_rd_op.size);
  assign w_resp_data   = (w_rd_op.store || w_rd_misalign) ? 64'd0 : w_mem_rdata;

  bp_be_dcache_trace_mem #(.els_p(els_p)) mem (
    .clk        (clk_i),
    .i_w_v      (w_accept & w_req.opcode.store & ~w_req_misalign),
    .i_w_index  (w_req.paddr[3 +: c_lg_els]),
    .i_w_offset (w_req.paddr[2:0]),
    .i_w_size   (w_req.opcode.size),
    .i_w_data   (w_req.data),
    .i_r_index  (w_rd_paddr[3 +: c_lg_els]),
    .i_r_offset (w_rd_paddr[2:0]),
    .i_r_size   (w_rd_op.size),
    .i_r_uns    (w_rd_op.uns),
    .o_r_data   (w_mem_rdata)
  );

  always_comb begin
    w_state_n     = r_state;
    tr_pkt_yumi_o = 1'b0;
    tr_pkt_v_o    = 1'b0;
    case (r_state)
      e_idle: begin
        tr_pkt_yumi_o = tr_pkt_v_i & reset_n_i;
        if (tr_pkt_v_i) w_state_n = (latency_p > 0) ? e_wait : e_resp;
      end
      e_wait: begin
        if (r_cnt == c_cnt_w'(1)) w_state_n = e_resp;
      end
      e_resp: begin
        tr_pkt_v_o = 1'b1;
        if (tr_pkt_ready_i) w_state_n = e_idle;
      end
      default: w_state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= e_idle;
      r_cnt       <= '0;
      r_req_op    <= '0;
      r_req_paddr <= '0;
      r_resp      <= '0;
      r_misalign  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (w_accept) begin
        r_req_op    <= w_req.opcode;
        r_req_paddr <= w_req.paddr;
        r_cnt       <= c_latency;
        r_misalign  <= r_misalign | w_req_misalign;
      end else if (r_state == e_wait) begin
        r_cnt <= r_cnt - c_cnt_w'(1);
      end
      if ((w_state_n == e_resp) && (r_state != e_resp)) begin
        r_resp.opcode <= w_rd_op;
        r_resp.paddr  <= w_rd_paddr;
        r_resp.data   <= w_resp_data;
      end
    end
  end

  assign tr_pkt_o   = r_resp;
  assign misalign_o = r_misalign;

endmodule

`default_nettype wire
